// File: rtl/mode_counter.sv
// Multi-mode counter: binary up/down, johnson, ring, gray, load and clear,
// with a registered terminal-count pulse and a saturating pulse counter.
module mode_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic [7:0]       tc_cnt
);

  typedef enum logic [2:0] {
    MODE_HOLD    = 3'd0,
    MODE_UP      = 3'd1,
    MODE_DOWN    = 3'd2,
    MODE_JOHNSON = 3'd3,
    MODE_RING    = 3'd4,
    MODE_GRAY    = 3'd5,
    MODE_LOAD    = 3'd6,
    MODE_CLEAR   = 3'd7
  } mode_e;

  mode_e            modeSel;
  logic [WIDTH-1:0] y_q, y_d;
  logic             tc_q, tc_d;
  logic [7:0]       tcCnt_q, tcCnt_d;
  logic [WIDTH-1:0] grayBin;
  logic [WIDTH-1:0] grayBinNext;

  assign modeSel = mode_e'(mode);

  // Gray-to-binary conversion of the current value, then step and re-encode.
  always_comb begin
    grayBin = '0;
    grayBin[WIDTH-1] = y_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      grayBin[i] = grayBin[i+1] ^ y_q[i];
    end
    grayBinNext = grayBin + 1'b1;
  end

  always_comb begin
    y_d     = y_q;
    tc_d    = 1'b0;
    tcCnt_d = tcCnt_q;
    case (modeSel)
      MODE_HOLD: y_d = y_q;
      MODE_UP: begin
        if (y_q >= limit) begin
          y_d  = '0;
          tc_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end
      MODE_DOWN: begin
        if (y_q == '0) begin
          y_d  = limit;
          tc_d = 1'b1;
        end else begin
          y_d = y_q - 1'b1;
        end
      end
      MODE_JOHNSON: begin
        y_d  = {~y_q[0], y_q[WIDTH-1:1]};
        tc_d = (y_d == '0);
      end
      MODE_RING: begin
        // An all-zero ring would never recover, so seed a single one at the MSB.
        if (y_q == '0) begin
          y_d = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          y_d = {y_q[0], y_q[WIDTH-1:1]};
        end
        tc_d = (y_d == {{(WIDTH-1){1'b0}}, 1'b1});
      end
      MODE_GRAY: begin
        y_d  = grayBinNext ^ (grayBinNext >> 1);
        tc_d = (y_d == '0);
      end
      MODE_LOAD: y_d = din;
      MODE_CLEAR: y_d = '0;
      default: y_d = y_q;
    endcase

    if (tc_d && (tcCnt_q != 8'hFF)) begin
      tcCnt_d = tcCnt_q + 8'd1;
    end
    if (modeSel == MODE_CLEAR) begin
      tcCnt_d = '0;
    end
  end

  // Disabled cycles freeze the value and pulse counter but still drop tc.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_q     <= '0;
      tc_q    <= 1'b0;
      tcCnt_q <= '0;
    end else if (en) begin
      y_q     <= y_d;
      tc_q    <= tc_d;
      tcCnt_q <= tcCnt_d;
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign y      = y_q;
  assign tc     = tc_q;
  assign tc_cnt = tcCnt_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed self-checking bench for mode_counter at WIDTH=4; each task covers
// one feature and compares outputs against hand-computed vectors.
module tb_mode_counter;

  logic       clock;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [3:0] din;
  logic [3:0] limit;
  logic [3:0] y;
  logic       tc;
  logic [7:0] tc_cnt;

  int checks = 0;
  int errors = 0;

  mode_counter #(.WIDTH(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .din    (din),
    .limit  (limit),
    .y      (y),
    .tc     (tc),
    .tc_cnt (tc_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] m,
                               input logic [3:0] d, input logic [3:0] l);
    reset = r;
    en    = e;
    mode  = m;
    din   = d;
    limit = l;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    stepClock();
    reset = 1'b0;
  endtask

  // Reset wins even with a count mode enabled.
  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 3'd1, 4'd7, 4'd5);
    stepClock();
    checks++;
    if (y !== 4'd0 || tc !== 1'b0 || tc_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset: y=%b tc=%b tc_cnt=%0d, expected y=0000 tc=0 tc_cnt=0", y, tc, tc_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_binary_up();
    logic [3:0] expY [7];
    logic       expTc [7];
    expY  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    expTc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd1, 4'd0, 4'd5);
    for (int i = 0; i < 7; i++) begin
      stepClock();
      checks++;
      if (y !== expY[i] || tc !== expTc[i]) begin
        errors++;
        $display("[TB] FAIL up edge %0d: y=%0d tc=%b, expected y=%0d tc=%b", i, y, tc, expY[i], expTc[i]);
      end
    end
    checks++;
    if (tc_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL up_tc_cnt: got %0d expected 1", tc_cnt);
    end
  endtask

  task automatic test_load_down();
    logic [3:0] expY [4];
    logic       expTc [4];
    expY  = '{4'd2, 4'd1, 4'd0, 4'd9};
    expTc = '{1'b0, 1'b0, 1'b0, 1'b1};
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd6, 4'b0011, 4'd0);
    stepClock();
    checks++;
    if (y !== 4'd3 || tc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load: y=%0d tc=%b, expected y=3 tc=0", y, tc);
    end
    applyStimulus(1'b0, 1'b1, 3'd2, 4'd0, 4'd9);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checks++;
      if (y !== expY[i] || tc !== expTc[i]) begin
        errors++;
        $display("[TB] FAIL down edge %0d: y=%0d tc=%b, expected y=%0d tc=%b", i, y, tc, expY[i], expTc[i]);
      end
    end
    checks++;
    if (tc_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL down_tc_cnt: got %0d expected 1", tc_cnt);
    end
  endtask

  task automatic test_johnson();
    logic [3:0] expY [8];
    expY = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd3, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      stepClock();
      checks++;
      if (y !== expY[i] || tc !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL johnson edge %0d: y=%b tc=%b, expected y=%b tc=%b", i, y, tc, expY[i], (i == 7));
      end
    end
  endtask

  task automatic test_ring_gray();
    logic [3:0] ringY [5];
    logic [3:0] grayY [16];
    ringY = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    grayY = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
              4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd4, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      stepClock();
      checks++;
      if (y !== ringY[i] || tc !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL ring edge %0d: y=%b tc=%b, expected y=%b tc=%b", i, y, tc, ringY[i], (i == 3));
      end
    end
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd5, 4'd0, 4'd3);
    for (int i = 0; i < 16; i++) begin
      stepClock();
      checks++;
      if (y !== grayY[i] || tc !== (i == 15)) begin
        errors++;
        $display("[TB] FAIL gray edge %0d: y=%b tc=%b, expected y=%b tc=%b", i, y, tc, grayY[i], (i == 15));
      end
    end
  endtask

  // limit=0 pulses tc every edge; the pulse counter must stop at 255.
  task automatic test_saturate();
    int expCnt;
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd1, 4'd0, 4'd0);
    expCnt = 0;
    for (int i = 0; i < 300; i++) begin
      stepClock();
      if (expCnt < 255) expCnt++;
      checks++;
      if (y !== 4'd0 || tc !== 1'b1 || tc_cnt !== expCnt[7:0]) begin
        errors++;
        $display("[TB] FAIL saturate edge %0d: y=%0d tc=%b tc_cnt=%0d, expected y=0 tc=1 tc_cnt=%0d", i, y, tc, tc_cnt, expCnt);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stepClock();
      checks++;
      if (y !== 4'd0 || tc !== 1'b0 || tc_cnt !== 8'd255) begin
        errors++;
        $display("[TB] FAIL freeze edge %0d: y=%0d tc=%b tc_cnt=%0d, expected y=0 tc=0 tc_cnt=255", i, y, tc, tc_cnt);
      end
    end
  endtask

  task automatic test_hold();
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd6, 4'd5, 4'd0);
    stepClock();
    applyStimulus(1'b0, 1'b1, 3'd0, 4'd9, 4'd0);
    stepClock();
    checks++;
    if (y !== 4'd5 || tc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold: y=%0d tc=%b, expected y=5 tc=0", y, tc);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd1, 4'd0, 4'd9);
    for (int i = 0; i < 3; i++) stepClock();
    checks++;
    if (y !== 4'd3) begin
      errors++;
      $display("[TB] FAIL pre_reset: y=%0d expected 3", y);
    end
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checks++;
    if (y !== 4'd0 || tc !== 1'b0 || tc_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: y=%0d tc=%b tc_cnt=%0d, expected 0 0 0", y, tc, tc_cnt);
    end
  endtask

  // Up count with limit=1 reaches terminal every second edge.
  task automatic test_clear();
    doReset();
    applyStimulus(1'b0, 1'b1, 3'd1, 4'd0, 4'd1);
    for (int i = 0; i < 4; i++) stepClock();
    checks++;
    if (y !== 4'd0 || tc !== 1'b1 || tc_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL pre_clear: y=%0d tc=%b tc_cnt=%0d, expected y=0 tc=1 tc_cnt=2", y, tc, tc_cnt);
    end
    stepClock();
    mode = 3'd7;
    stepClock();
    checks++;
    if (y !== 4'd0 || tc !== 1'b0 || tc_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL clear: y=%0d tc=%b tc_cnt=%0d, expected y=0 tc=0 tc_cnt=0", y, tc, tc_cnt);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    test_reset();
    test_binary_up();
    test_load_down();
    test_johnson();
    test_ring_gray();
    test_saturate();
    test_hold();
    test_reset_mid();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 SHALL have port en  input  1  count enable; 0 freezes all state.
REQ-005 SHALL have port mode  input  3  operation select (see REQ-010).
REQ-006 SHALL have port din  input  WIDTH  parallel load value.
REQ-007 SHALL have port limit  input  WIDTH  terminal value for binary up/down modes.
REQ-008 SHALL have port y  output  WIDTH  registered counter value.
REQ-009 SHALL have ports tc  output  1  registered terminal-count pulse, and tc_cnt  output  8  registered saturating count of tc pulses.

Function
REQ-010 SHALL decode mode as: 0 hold; 1 binary up; 2 binary down; 3 johnson; 4 ring; 5 gray up; 6 load; 7 clear.
REQ-011 SHALL update y, tc and tc_cnt only on rising clock edges; there are no combinational paths from inputs to outputs.
REQ-012 SHALL, when en=0 and reset=0, hold y and tc_cnt and drive tc=0 on the next edge.
REQ-013 Mode 0 SHALL hold y and drive tc=0.
REQ-014 Mode 1 SHALL set y to 0 with tc=1 when y>=limit; otherwise it SHALL set y to y+1 with tc=0.
REQ-015 Mode 1 with limit=0 SHALL hold y=0 and pulse tc every enabled cycle.
REQ-016 Mode 2 SHALL set y to limit with tc=1 when y==0; otherwise it SHALL set y to y-1 with tc=0.
REQ-017 Mode 3 SHALL set y to {~y[0], y[WIDTH-1:1]}; tc=1 iff the new y is all-zeros; the period is 2*WIDTH; invalid states are not corrected.
REQ-018 Mode 4 SHALL rotate right, y to {y[0], y[WIDTH-1:1]}; if y==0 it SHALL instead load 1 in the MSB only (self-start); tc=1 iff the new y equals 1.
REQ-019 Mode 5 SHALL treat y as a reflected Gray code and set it to gray(bin(y)+1) modulo 2^WIDTH; tc=1 iff the new y is 0; limit is ignored.
REQ-020 Mode 6 SHALL set y to din with tc=0 and hold tc_cnt.
REQ-021 Mode 7 SHALL set y to 0, tc to 0 and tc_cnt to 0.
REQ-022 SHALL increment tc_cnt by 1 in the same edge that asserts tc=1, saturating at 255.
REQ-023 SHALL apply a mode change on the next enabled edge using the current y as the starting state, with no implicit clear.
REQ-024 SHALL make tc a single-cycle pulse per terminal event; consecutive terminal events produce consecutive pulses.
REQ-025 SHALL sample limit and din each edge; changing them mid-count affects only the next edge.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set y=0, tc=0 and tc_cnt=0, regardless of en and mode.
REQ-027 Reset SHALL take priority over every other input, including a reset asserted mid-sequence.
REQ-028 SHALL, on the first edge after reset deasserts, apply the mode rules to y=0.

Verification (WIDTH=4)
REQ-029 Bench SHALL cover: reset, then mode=1, limit=5, en=1 for 7 edges -> y=1,2,3,4,5,0,1; tc=1 only with y=0; tc_cnt=1.
REQ-030 Bench SHALL cover: mode=6, din=0011, then mode=2, limit=9 for 5 edges -> y=3,2,1,0,9; tc=1 with y=9.
REQ-031 Bench SHALL cover: from reset, mode=3 for 8 edges -> y=1000,1100,1110,1111,0111,0011,0001,0000; tc=1 only on the last edge.
REQ-032 Bench SHALL cover: from reset, mode=4 for 5 edges -> y=1000,0100,0010,0001,1000; tc=1 with 0001. Then mode=5 from reset for 16 edges -> y=0001,0011,0010,0110,…,1000,0000; tc=1 only at 0000.
REQ-033 Bench SHALL cover: mode=1, limit=0, en=1 for 300 edges -> tc=1 every edge; tc_cnt saturates at 255. Then en=0 for 2 edges -> y and tc_cnt held, tc=0.
REQ-034 Bench SHALL cover: reset=1 asserted during a mode=1 count at y=3 -> next y=0, tc=0, tc_cnt=0. Then mode=7 after tc_cnt=2 -> tc_cnt=0, y=0.
